// File: rtl/dcache_mem_ctrl_if.sv
// dcache_mem_ctrl_if: cache request streams, shared memory port and refill signals of dcache_mem_ctrl
// slave modport faces the controller, master modport faces the cache/memory side.
interface dcache_mem_ctrl_if #(
  parameter int LSQ_SZ = 8
);
  logic              wb_en, wr_en, rd_en;
  logic [15:0]       wb_addr, wr_addr, rd_addr;
  logic [63:0]       wb_data, wr_data;
  logic [1:0]        wb_size, wr_size, rd_size;
  logic [LSQ_SZ-1:0] rd_gnt;
  logic              req_full;
  logic              mem_grant;
  logic [1:0]        proc2mem_command;
  logic [15:0]       proc2mem_addr;
  logic [63:0]       proc2mem_data;
  logic [1:0]        proc2mem_size;
  logic [3:0]        mem2proc_response;
  logic [63:0]       mem2proc_data;
  logic [3:0]        mem2proc_tag;
  logic              mem_wr_en;
  logic [4:0]        mem_wr_idx;
  logic [7:0]        mem_wr_tag;
  logic [63:0]       mem_wr_data;
  logic [LSQ_SZ-1:0] fill_gnt;
  modport slave (
    input  wb_en, wb_addr, wb_data, wb_size, wr_en, wr_addr, wr_data, wr_size,
           rd_en, rd_addr, rd_size, rd_gnt, mem_grant, mem2proc_response, mem2proc_data, mem2proc_tag,
    output req_full, proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
           mem_wr_en, mem_wr_idx, mem_wr_tag, mem_wr_data, fill_gnt
  );
  modport master (
    output wb_en, wb_addr, wb_data, wb_size, wr_en, wr_addr, wr_data, wr_size,
           rd_en, rd_addr, rd_size, rd_gnt, mem_grant, mem2proc_response, mem2proc_data, mem2proc_tag,
    input  req_full, proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
           mem_wr_en, mem_wr_idx, mem_wr_tag, mem_wr_data, fill_gnt
  );
endinterface

// File: rtl/dcache_mem_ctrl.sv
// dcache_mem_ctrl: serialises cache wb/wr/rd requests in arrival order onto one memory port and returns load fills
// Ports: clock, reset (sync, active-high); bus (dcache_mem_ctrl_if.slave) = cache requests, memory port, refill outputs.
// Optional: define DCMC_RD_MERGE_EN to fold a new rd into a queued or outstanding load of the same block.
module dcache_mem_ctrl #(
  parameter int LSQ_SZ = 8,
  parameter int QDEPTH = 8
) (
  input logic clock,
  input logic reset,
  dcache_mem_ctrl_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [1:0] BUS_NONE = 2'h0, BUS_LOAD = 2'h1, BUS_STORE = 2'h2, DOUBLE = 2'h3;
  logic [QDEPTH-1:0] ld_q, ld_d;
  logic [15:0] addr_q [QDEPTH], addr_d [QDEPTH];
  logic [63:0] data_q [QDEPTH], data_d [QDEPTH];
  logic [1:0] size_q [QDEPTH], size_d [QDEPTH];
  logic [LSQ_SZ-1:0] gnt_q [QDEPTH], gnt_d [QDEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, pos;
  logic [PW:0] cnt_q, cnt_d;
  logic [15:0] tv_q, tv_d;
  logic [12:0] tblk_q [16], tblk_d [16];
  logic [LSQ_SZ-1:0] tgnt_q [16], tgnt_d [16];
  logic wr_en_q, wr_en_d;
  logic [4:0] wr_idx_q, wr_idx_d;
  logic [7:0] wr_tag_q, wr_tag_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic [LSQ_SZ-1:0] fill_q, fill_d;
  logic issue, pop, ret, rd_push;
  logic [2:0] en;
  logic [15:0] c_addr [3];
  logic [63:0] c_data [3];
  logic [1:0] c_size [3];
  logic [LSQ_SZ-1:0] c_gnt [3];
`ifdef DCMC_RD_MERGE_EN
  logic merged, st_seen;
  logic [PW-1:0] idx;
`endif
  assign bus.req_full = cnt_q > (PW+1)'(QDEPTH - 3);
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_wr_idx = wr_idx_q;
  assign bus.mem_wr_tag = wr_tag_q;
  assign bus.mem_wr_data = wr_data_q;
  assign bus.fill_gnt = fill_q;
  // a load head stalls while every tag slot is busy; stores behind it wait too, keeping order
  always_comb begin
    issue = cnt_q != '0 && bus.mem_grant && !(ld_q[head_q] && &tv_q[15:1]);
    pop = issue && bus.mem2proc_response != 4'd0;
    ret = bus.mem2proc_tag != 4'd0 && tv_q[bus.mem2proc_tag];
    bus.proc2mem_command = !issue ? BUS_NONE : ld_q[head_q] ? BUS_LOAD : BUS_STORE;
    bus.proc2mem_addr = issue ? addr_q[head_q] : '0;
    bus.proc2mem_data = issue ? data_q[head_q] : '0;
    bus.proc2mem_size = issue ? size_q[head_q] : '0;
  end
  always_comb begin
    ld_d = ld_q;
    addr_d = addr_q;
    data_d = data_q;
    size_d = size_q;
    gnt_d = gnt_q;
    tv_d = tv_q;
    tblk_d = tblk_q;
    tgnt_d = tgnt_q;
    head_d = pop ? head_q + PW'(1) : head_q;
    // return clears the slot first so a same-cycle accept with that tag rewrites it
    if (ret) tv_d[bus.mem2proc_tag] = 1'b0;
    if (pop && ld_q[head_q]) begin
      tv_d[bus.mem2proc_response] = 1'b1;
      tblk_d[bus.mem2proc_response] = addr_q[head_q][15:3];
      tgnt_d[bus.mem2proc_response] = gnt_q[head_q];
    end
    rd_push = bus.rd_en;
`ifdef DCMC_RD_MERGE_EN
    merged = 1'b0;
    st_seen = (bus.wb_en && bus.wb_addr[15:3] == bus.rd_addr[15:3]) || (bus.wr_en && bus.wr_addr[15:3] == bus.rd_addr[15:3]);
    idx = '0;
    if (bus.rd_en && !bus.req_full) begin
      // walk youngest to oldest: st_seen marks a same-block store queued behind the candidate rd
      for (int k = QDEPTH - 1; k >= 0; k--) begin
        idx = head_q + PW'(k);
        if (k < int'(cnt_q) && !(pop && k == 0)) begin
          if (ld_q[idx] && addr_q[idx][15:3] == bus.rd_addr[15:3] && !st_seen && !merged) begin
            gnt_d[idx] = gnt_q[idx] | bus.rd_gnt;
            merged = 1'b1;
          end
          if (!ld_q[idx] && addr_q[idx][15:3] == bus.rd_addr[15:3]) st_seen = 1'b1;
        end
      end
      for (int t = 1; t < 16; t++)
        if (tv_q[t] && !(ret && bus.mem2proc_tag == 4'(t)) && tblk_q[t] == bus.rd_addr[15:3] && !st_seen && !merged) begin
          tgnt_d[t] = tgnt_q[t] | bus.rd_gnt;
          merged = 1'b1;
        end
    end
    rd_push = bus.rd_en && !merged;
`endif
    en = bus.req_full ? 3'b000 : {rd_push, bus.wr_en, bus.wb_en};
    c_addr = '{bus.wb_addr, bus.wr_addr, {bus.rd_addr[15:3], 3'b000}};
    c_data = '{bus.wb_data, bus.wr_data, 64'd0};
    c_size = '{bus.wb_size, bus.wr_size, DOUBLE};
    c_gnt = '{{LSQ_SZ{1'b0}}, {LSQ_SZ{1'b0}}, bus.rd_gnt};
    pos = tail_q;
    for (int k = 0; k < 3; k++)
      if (en[k]) begin
        ld_d[pos] = k == 2;
        addr_d[pos] = c_addr[k];
        data_d[pos] = c_data[k];
        size_d[pos] = c_size[k];
        gnt_d[pos] = c_gnt[k];
        pos = pos + PW'(1);
      end
    tail_d = pos;
    cnt_d = cnt_q + (PW+1)'(en[0]) + (PW+1)'(en[1]) + (PW+1)'(en[2]) - (PW+1)'(pop);
    wr_en_d = ret;
    wr_idx_d = ret ? tblk_q[bus.mem2proc_tag][4:0] : '0;
    wr_tag_d = ret ? tblk_q[bus.mem2proc_tag][12:5] : '0;
    wr_data_d = ret ? bus.mem2proc_data : '0;
    fill_d = ret ? tgnt_q[bus.mem2proc_tag] : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      tv_q <= '0;
      wr_en_q <= 1'b0;
      wr_idx_q <= '0;
      wr_tag_q <= '0;
      wr_data_q <= '0;
      fill_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      tv_q <= tv_d;
      wr_en_q <= wr_en_d;
      wr_idx_q <= wr_idx_d;
      wr_tag_q <= wr_tag_d;
      wr_data_q <= wr_data_d;
      fill_q <= fill_d;
    end
    ld_q <= ld_d;
    addr_q <= addr_d;
    data_q <= data_d;
    size_q <= size_d;
    gnt_q <= gnt_d;
    tblk_q <= tblk_d;
    tgnt_q <= tgnt_d;
  end
  assert property (@(posedge clock) disable iff (reset) bus.req_full |-> !(bus.wb_en || bus.wr_en || bus.rd_en));
endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// tb_dcache_mem_ctrl: queue/table reference model checked every cycle plus directed literal expectations
module tb_dcache_mem_ctrl;
  localparam int LSQ_SZ = 8, QDEPTH = 8;
  typedef struct packed {logic ld; logic [15:0] addr; logic [63:0] data; logic [1:0] size; logic [7:0] gnt;} ent_t;
  typedef struct packed {logic [4:0] idx; logic [7:0] tag; logic [7:0] gnt; logic [63:0] data;} fill_t;
  logic clock = 0, reset = 1;
  int checks = 0, errors = 0;
  bit started = 0;
  always #5 clock = ~clock;
  dcache_mem_ctrl_if #(.LSQ_SZ(LSQ_SZ)) bus();
  dcache_mem_ctrl #(.LSQ_SZ(LSQ_SZ), .QDEPTH(QDEPTH)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
  ent_t mq[$];
  bit [15:0] tv;
  logic [15:0] tad [16];
  logic [7:0] tg [16];
  logic ew_en;
  logic [4:0] ew_idx;
  logic [7:0] ew_tag, ew_gnt;
  logic [63:0] ew_data;
  bit m_full, m_iss, m_acc, m_merged;
  int m_t;
  ent_t m_head;
  logic [17:0] cmd_log[$];
  fill_t fill_log[$];
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      tv = '0;
      {ew_en, ew_idx, ew_tag, ew_gnt, ew_data} = '0;
      started = 1;
    end else begin
      m_full = mq.size() > QDEPTH - 3;
      m_iss = mq.size() != 0 && bus.mem_grant && !(mq[0].ld && $countones(tv[15:1]) == 15);
      m_acc = m_iss && bus.mem2proc_response != 0;
      m_t = int'(bus.mem2proc_tag);
      if (m_t != 0 && tv[m_t]) begin
        ew_en = 1; ew_idx = tad[m_t][7:3]; ew_tag = tad[m_t][15:8]; ew_data = bus.mem2proc_data; ew_gnt = tg[m_t];
        tv[m_t] = 0;
      end else {ew_en, ew_idx, ew_tag, ew_gnt, ew_data} = '0;
      if (m_acc) m_head = mq.pop_front();
      if (!m_full) begin
        if (bus.wb_en) mq.push_back({1'b0, bus.wb_addr, bus.wb_data, bus.wb_size, 8'h00});
        if (bus.wr_en) mq.push_back({1'b0, bus.wr_addr, bus.wr_data, bus.wr_size, 8'h00});
        if (bus.rd_en) begin
          m_merged = 0;
`ifdef DCMC_RD_MERGE_EN
          for (int k = mq.size() - 1; k >= 0; k--) begin
            if (mq[k].addr[15:3] == bus.rd_addr[15:3] && !mq[k].ld) break;
            if (mq[k].addr[15:3] == bus.rd_addr[15:3]) begin
              mq[k].gnt = mq[k].gnt | bus.rd_gnt;
              m_merged = 1;
              break;
            end
          end
          if (!m_merged && !(bus.wb_en && bus.wb_addr[15:3] == bus.rd_addr[15:3]) && !(bus.wr_en && bus.wr_addr[15:3] == bus.rd_addr[15:3])) begin
            m_merged = 1;
            foreach (mq[k]) if (!mq[k].ld && mq[k].addr[15:3] == bus.rd_addr[15:3]) m_merged = 0;
            if (m_merged) begin
              m_merged = 0;
              for (int t = 1; t < 16; t++)
                if (!m_merged && tv[t] && tad[t][15:3] == bus.rd_addr[15:3]) begin
                  tg[t] = tg[t] | bus.rd_gnt;
                  m_merged = 1;
                end
            end
          end
`endif
          if (!m_merged) mq.push_back({1'b1, bus.rd_addr[15:3], 3'b000, 64'd0, 2'h3, bus.rd_gnt});
        end
      end
      if (m_acc && m_head.ld) begin
        tv[bus.mem2proc_response] = 1;
        tad[bus.mem2proc_response] = m_head.addr;
        tg[bus.mem2proc_response] = m_head.gnt;
      end
    end
  end
  always @(negedge clock) if (started) begin
    m_iss = mq.size() != 0 && bus.mem_grant && !(mq[0].ld && $countones(tv[15:1]) == 15);
    chk("cmd", bus.proc2mem_command, !m_iss ? 2'h0 : mq[0].ld ? 2'h1 : 2'h2);
    chk("addr", bus.proc2mem_addr, m_iss ? mq[0].addr : 16'h0);
    chk("data", bus.proc2mem_data, m_iss ? mq[0].data : 64'h0);
    chk("size", bus.proc2mem_size, m_iss ? mq[0].size : 2'h0);
    chk("req_full", bus.req_full, mq.size() > QDEPTH - 3);
    chk("mem_wr_en", bus.mem_wr_en, ew_en);
    chk("mem_wr_idx", bus.mem_wr_idx, ew_idx);
    chk("mem_wr_tag", bus.mem_wr_tag, ew_tag);
    chk("mem_wr_data", bus.mem_wr_data, ew_data);
    chk("fill_gnt", bus.fill_gnt, ew_gnt);
    if (bus.proc2mem_command != 2'h0) cmd_log.push_back({bus.proc2mem_command, bus.proc2mem_addr});
    if (bus.mem_wr_en) fill_log.push_back({bus.mem_wr_idx, bus.mem_wr_tag, bus.fill_gnt, bus.mem_wr_data});
  end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic idle();
    {bus.wb_en, bus.wr_en, bus.rd_en, bus.mem_grant} = '0;
    {bus.wb_addr, bus.wr_addr, bus.rd_addr} = '0;
    {bus.wb_data, bus.wr_data, bus.mem2proc_data} = '0;
    {bus.wb_size, bus.wr_size, bus.rd_size, bus.rd_gnt} = '0;
    {bus.mem2proc_response, bus.mem2proc_tag} = '0;
  endtask
  task automatic rd(logic [15:0] a, logic [7:0] g);
    bus.rd_en = 1; bus.rd_addr = a; bus.rd_gnt = g; bus.rd_size = 2'h1;
    tick();
    bus.rd_en = 0;
  endtask
  task automatic ret(logic [3:0] t, logic [63:0] d);
    bus.mem2proc_tag = t; bus.mem2proc_data = d;
    tick();
    bus.mem2proc_tag = 0; bus.mem2proc_data = 0;
  endtask
  logic [15:0] t3_addr [6] = '{16'h0100, 16'h0208, 16'h0310, 16'h0400, 16'h0508, 16'h0610};
  initial begin
    idle();
    tick(2);
    reset = 0;
    @(negedge clock);
    chk("rst_cmd", bus.proc2mem_command, 2'h0);
    chk("rst_full", bus.req_full, 1'b0);
    chk("rst_wr_en", bus.mem_wr_en, 1'b0);
    chk("rst_fill", bus.fill_gnt, 8'h00);
    tick();
    // three streams in one cycle, issued in wb/wr/rd order
    cmd_log.delete(); fill_log.delete();
    bus.wb_en = 1; bus.wb_addr = 16'h1200; bus.wb_data = 64'hAAAA_0000_1111_2222; bus.wb_size = 2'h3;
    bus.wr_en = 1; bus.wr_addr = 16'h3408; bus.wr_data = 64'h5555_6666_7777_8888; bus.wr_size = 2'h2;
    bus.rd_en = 1; bus.rd_addr = 16'h5610; bus.rd_gnt = 8'h04; bus.rd_size = 2'h1; bus.mem_grant = 1;
    tick();
    {bus.wb_en, bus.wr_en, bus.rd_en} = '0;
    for (int i = 1; i <= 3; i++) begin
      bus.mem2proc_response = 4'(i);
      tick();
    end
    bus.mem2proc_response = 0; bus.mem_grant = 0;
    ret(3, 64'hDEAD_BEEF_0123_4567);
    tick();
    chk("t1_ncmd", cmd_log.size(), 3);
    if (cmd_log.size() == 3) begin
      chk("t1_c0", cmd_log[0], {2'h2, 16'h1200});
      chk("t1_c1", cmd_log[1], {2'h2, 16'h3408});
      chk("t1_c2", cmd_log[2], {2'h1, 16'h5610});
    end
    chk("t1_nfill", fill_log.size(), 1);
    if (fill_log.size() == 1) chk("t1_fill", fill_log[0], {5'd2, 8'h56, 8'h04, 64'hDEAD_BEEF_0123_4567});
    // rejected load retries in place
    cmd_log.delete(); fill_log.delete();
    rd(16'h778C, 8'h10);
    bus.mem_grant = 1;
    tick(3);
    bus.mem2proc_response = 5;
    tick();
    bus.mem2proc_response = 0; bus.mem_grant = 0;
    tick();
    chk("t2_ncmd", cmd_log.size(), 4);
    foreach (cmd_log[i]) chk("t2_cmd", cmd_log[i], {2'h1, 16'h7788});
    ret(5, 64'h1);
    tick();
    chk("t2_nfill", fill_log.size(), 1);
    if (fill_log.size() == 1) chk("t2_fill", fill_log[0], {5'd17, 8'h77, 8'h10, 64'h1});
    // fill to 6 entries, req_full high until first pop
    cmd_log.delete(); fill_log.delete();
    for (int c = 0; c < 2; c++) begin
      bus.wb_en = 1; bus.wb_addr = t3_addr[3*c]; bus.wb_data = 64'(c + 10); bus.wb_size = 2'h3;
      bus.wr_en = 1; bus.wr_addr = t3_addr[3*c+1]; bus.wr_data = 64'(c + 20); bus.wr_size = 2'h0;
      bus.rd_en = 1; bus.rd_addr = t3_addr[3*c+2]; bus.rd_gnt = 8'(1 << c);
      tick();
    end
    {bus.wb_en, bus.wr_en, bus.rd_en} = '0;
    @(negedge clock);
    chk("t3_full6", bus.req_full, 1'b1);
    tick();
    bus.mem_grant = 1; bus.mem2proc_response = 9;
    tick();
    bus.mem2proc_response = 10;
    @(negedge clock);
    chk("t3_full5", bus.req_full, 1'b0);
    tick();
    for (int r = 11; r <= 14; r++) begin
      bus.mem2proc_response = 4'(r);
      tick();
    end
    bus.mem_grant = 0; bus.mem2proc_response = 0;
    ret(14, 64'h14);
    ret(11, 64'h11);
    tick();
    chk("t3_ncmd", cmd_log.size(), 6);
    foreach (cmd_log[i]) chk("t3_cmd", cmd_log[i][15:0], t3_addr[i]);
    chk("t3_nfill", fill_log.size(), 2);
    if (fill_log.size() == 2) begin
      chk("t3_f0", fill_log[0], {5'd2, 8'h06, 8'h02, 64'h14});
      chk("t3_f1", fill_log[1], {5'd2, 8'h03, 8'h01, 64'h11});
    end
    // out-of-order returns
    fill_log.delete();
    rd(16'h2340, 8'h20);
    rd(16'h9AB8, 8'h40);
    bus.mem_grant = 1; bus.mem2proc_response = 4;
    tick();
    bus.mem2proc_response = 7;
    tick();
    bus.mem_grant = 0; bus.mem2proc_response = 0;
    ret(7, 64'h77);
    ret(4, 64'h44);
    tick();
    chk("t4_nfill", fill_log.size(), 2);
    if (fill_log.size() == 2) begin
      chk("t4_f0", fill_log[0], {5'd23, 8'h9A, 8'h40, 64'h77});
      chk("t4_f1", fill_log[1], {5'd8, 8'h23, 8'h20, 64'h44});
    end
    // return and re-accept of the same tag in one cycle
    fill_log.delete();
    rd(16'h1118, 8'h01);
    bus.mem_grant = 1; bus.mem2proc_response = 2;
    tick();
    bus.mem_grant = 0; bus.mem2proc_response = 0;
    rd(16'h2228, 8'h02);
    bus.mem_grant = 1; bus.mem2proc_response = 2;
    ret(2, 64'hD1);
    bus.mem_grant = 0; bus.mem2proc_response = 0;
    ret(2, 64'hD2);
    tick();
    chk("t5_nfill", fill_log.size(), 2);
    if (fill_log.size() == 2) begin
      chk("t5_f0", fill_log[0], {5'd3, 8'h11, 8'h01, 64'hD1});
      chk("t5_f1", fill_log[1], {5'd5, 8'h22, 8'h02, 64'hD2});
    end
    // reset with loads outstanding and a queued store
    rd(16'h4440, 8'h01);
    rd(16'h4548, 8'h02);
    bus.mem_grant = 1; bus.mem2proc_response = 1;
    tick();
    bus.mem2proc_response = 2;
    tick();
    bus.mem_grant = 0; bus.mem2proc_response = 0;
    bus.wb_en = 1; bus.wb_addr = 16'h6600; bus.wb_data = 64'h66;
    tick();
    bus.wb_en = 0;
    reset = 1;
    tick(2);
    reset = 0;
    cmd_log.delete(); fill_log.delete();
    bus.mem_grant = 1; bus.mem2proc_response = 3;
    ret(1, 64'hA1);
    ret(2, 64'hA2);
    tick();
    bus.mem_grant = 0; bus.mem2proc_response = 0;
    chk("t6_nfill", fill_log.size(), 0);
    chk("t6_ncmd", cmd_log.size(), 0);
`ifdef DCMC_RD_MERGE_EN
    rd(16'h5610, 8'h01);
    bus.mem_grant = 1; bus.mem2proc_response = 1;
    tick();
    bus.mem_grant = 0; bus.mem2proc_response = 0;
    cmd_log.delete(); fill_log.delete();
    rd(16'h5614, 8'h02);
    bus.mem_grant = 1; bus.mem2proc_response = 2;
    tick(2);
    bus.mem_grant = 0; bus.mem2proc_response = 0;
    chk("m_ncmd", cmd_log.size(), 0);
    ret(1, 64'hBB);
    tick();
    chk("m_nfill", fill_log.size(), 1);
    if (fill_log.size() == 1) chk("m_fill", fill_log[0], {5'd2, 8'h56, 8'h03, 64'hBB});
`endif
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_mem_ctrl.md
Name: dcache_mem_ctrl

Overview:
- Sits directly downstream of the data cache. It accepts the cache's three memory-bound request streams: dirty-victim writeback, write-miss store and read-miss load.
- Requests are serialised in arrival order onto the single shared memory port.
- Load tags are tracked until the data returns. Fill data is then handed back to the cache (refill interface) and the waiting LSQ grant bits are returned.

Parameters:
- LSQ_SZ, 8: width of LSQ grant vectors; equals the codebase `LSQSZ.
- QDEPTH, 8: request FIFO entries; power of two, minimum 4.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- wb_en / wb_addr / wb_data / wb_size  in  1/16/64/2  dirty writeback from cache
- wr_en / wr_addr / wr_data / wr_size  in  1/16/64/2  write-miss store from cache
- rd_en / rd_addr / rd_size / rd_gnt  in  1/16/2/LSQ_SZ  read-miss load from cache
- req_full  out  1  fewer than 3 FIFO slots free; the cache holds all requests while this is high
- mem_grant  in  1  shared-port arbiter grants this block this cycle
- proc2mem_command  out  2  BUS_NONE/BUS_LOAD/BUS_STORE
- proc2mem_addr  out  16  request address
- proc2mem_data  out  64  store data
- proc2mem_size  out  2  request size
- mem2proc_response  in  4  acceptance tag; 0 means rejected
- mem2proc_data  in  64  load return data
- mem2proc_tag  in  4  tag of returning load; 0 means none
- mem_wr_en / mem_wr_idx / mem_wr_tag / mem_wr_data  out  1/5/8/64  refill to cache
- fill_gnt  out  LSQ_SZ  LSQ entries whose miss is now filled

Behaviour:
- Reset: FIFO empty; outstanding table all invalid; all outputs 0; proc2mem_command = BUS_NONE.
- Enqueue, same cycle: up to 3 entries are pushed in the fixed order wb, wr, rd.
- Each entry holds {kind, addr, data, size, gnt}.
- A rd entry stores its address block-aligned ({addr[15:3], 3'b0}) and its size forced to DOUBLE.
- Any enqueue while req_full=1 is a protocol violation: it is dropped and asserted in simulation.
- Issue: combinational from the FIFO head when it is non-empty and mem_grant=1.
  - Store kinds drive BUS_STORE with the head's addr, data and size.
  - rd drives BUS_LOAD.
  - FIFO empty or mem_grant=0 drives BUS_NONE; addr, data and size are then 0.
- Accept: in the same cycle as issue, mem2proc_response != 0 pops the head.
  - For a load, the outstanding table slot [response] is also written with {valid, block addr, gnt}.
  - response = 0 leaves the head in place; it retries next granted cycle and never skips ahead.
- Loads are never issued while the table slot count valid = 15. The head waits.
- Return: mem2proc_tag = t != 0 with slot t valid.
  - Next cycle: mem_wr_en=1; mem_wr_idx = addr[7:3]; mem_wr_tag = addr[15:8]; mem_wr_data = the registered mem2proc_data; fill_gnt = slot gnt. All outputs are registered, giving 1-cycle latency.
  - Slot t is invalidated in the same cycle the tag arrives.
  - A tag arriving for an invalid slot is ignored.
- Tag return and acceptance of a new load with the same tag in one cycle: the return is processed first, then the slot is rewritten.
- req_full = (free slots < 3); it is computed from registered state only.
- Ordering: a load never passes an older store in the FIFO, so store-to-load order in memory is preserved.
- Reset mid-operation: queue and table are cleared. Later tag returns hit invalid slots and are dropped.
- mem_wr_en and fill_gnt are single-cycle pulses.

Optional Feature:
- DCMC_RD_MERGE_EN defined: a new rd whose block address matches a queued rd entry or a valid outstanding slot is not enqueued. Its rd_gnt is ORed into the matching entry or slot.
  - Store-ordering guard: there is no merge if a store entry to the same block is queued behind the matching rd.
- Undefined: every rd enqueues a separate load; duplicate fills are delivered (the cache ignores them as conflicts).

Test Plan:
- wb(0x1200), wr(0x3408), rd(0x5610, gnt=8'h04) in one cycle, mem_grant=1, responses 1,2,3 -> commands STORE 0x1200, STORE 0x3408, LOAD 0x5610 in order. Later tag 3 -> next cycle mem_wr_idx=2, mem_wr_tag=0x56, fill_gnt=8'h04.
- LOAD head with response=0 for 3 cycles, then 5 -> same addr re-driven on each of the 4 cycles; exactly one pop.
- Enqueue 6 entries with mem_grant=0, QDEPTH=8 -> req_full=1 once 6 are held; deasserts after the first accepted pop.
- Two loads accepted as tags 4 and 7; tag 7 returns before tag 4 -> refills in return order, each with its own addr and gnt.
- Reset while 2 loads are outstanding, then tags return -> no mem_wr_en; all outputs 0.
- With DCMC_RD_MERGE_EN: rd 0x5610 gnt 0x01 outstanding, then rd 0x5614 gnt 0x02 -> no new LOAD; the fill returns fill_gnt=0x03.
